// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path.
// Contents:
//   - opcode class encodings (Instruction[15:12])
//   - sequencer state encoding (3 bits)
//   - opcode legality helper used by DECODE
package cpu_pkg;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_LW   = 4'h1;
  localparam logic [3:0] OP_SW   = 4'h2;
  localparam logic [3:0] OP_BEQ  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  // True for every opcode class the sequencer knows how to step.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Wait-cycle timer shared by the FETCH and MEM handshakes.
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset, clears the count
//   clr_i      clear the count (takes priority over en_i)
//   en_i       count one more unacknowledged cycle
//   expired_o  high during the LIMIT-th unacknowledged cycle of a wait
module seq_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // The count holds the number of unacked cycles already spent, so the
  // LIMIT-th waiting cycle is the one where it reads LIMIT-1. An ack in that
  // same cycle still wins because the caller checks ack before expired_o.
  localparam logic [3:0] LAST = 4'(LIMIT - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Multi-cycle control sequencer for the 16-bit CPU. Owns the PC and steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, issuing per-state enables to
// the datapath. Fetch and load/store use req/ack handshakes so memories may
// stall; a stall longer than MEM_TIMEOUT cycles lands in FAULT.
//
// Handshake: a request is held high every cycle the sequencer waits in FETCH
// or MEM; the cycle in which the matching ack is seen completes the transfer
// and the request drops on the next cycle. An ack outside a request is ignored.
//
// Ports:
//   clk_i             rising-edge clock
//   rst_i             synchronous active-high reset
//   opcode_i          Instruction[15:12] from the instruction register
//   alu_zero_i        ALU zero flag, used in EXEC
//   branch_tgt_i      BEQ target from the datapath
//   imem_ack_i        instruction memory done, data valid this cycle
//   dmem_ack_i        data memory done
//   retired_ld_i      debug preload strobe for the retire counter
//   retired_ld_val_i  debug preload value for the retire counter
//   pc_o              current PC
//   imem_req_o        fetch request
//   dmem_req_o        data access request
//   dmem_we_o         1=store, 0=load (qualified by dmem_req_o)
//   ir_write_o        latch instruction into IR
//   reg_write_o       register file write strobe
//   mem_to_reg_o      WB source: 1=memory, 0=ALU
//   alu_src_imm_o     ALU B operand = immediate
//   halted_o          HALT executed
//   fault_o           illegal opcode or memory timeout
//   retired_o         retired-instruction count (wraps)
//   state_o           current FSM state, for debug/checkers
module cpu_cycle_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter logic [PC_W-1:0] RESET_PC    = 16'd10,
  parameter int              PC_STEP     = 1,
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [3:0]      opcode_i,
  input  logic            alu_zero_i,
  input  logic [PC_W-1:0] branch_tgt_i,
  input  logic            imem_ack_i,
  input  logic            dmem_ack_i,
  input  logic            retired_ld_i,
  input  logic [15:0]     retired_ld_val_i,
  output logic [PC_W-1:0] pc_o,
  output logic            imem_req_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic            ir_write_o,
  output logic            reg_write_o,
  output logic            mem_to_reg_o,
  output logic            alu_src_imm_o,
  output logic            halted_o,
  output logic            fault_o,
  output logic [15:0]     retired_o,
  output logic [2:0]      state_o
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      op_q, op_d;
  logic [15:0]     retired_q, retired_d;
  logic            retire;
  logic            timer_clr;
  logic            timer_en;
  logic            timer_expired;

  seq_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    op_d          = op_q;
    retire        = 1'b0;
    // Outside FETCH/MEM the timer sits at zero so every wait starts fresh.
    timer_clr     = 1'b1;
    timer_en      = 1'b0;
    imem_req_o    = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_we_o     = 1'b0;
    ir_write_o    = 1'b0;
    reg_write_o   = 1'b0;
    mem_to_reg_o  = 1'b0;
    alu_src_imm_o = 1'b0;
    halted_o      = 1'b0;
    fault_o       = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        imem_req_o = 1'b1;
        timer_clr  = imem_ack_i;
        timer_en   = !imem_ack_i;
        if (imem_ack_i) begin
          ir_write_o = 1'b1;
          pc_d       = pc_q + STEP;
          state_d    = S_DECODE;
        end else if (timer_expired) begin
          state_d = S_FAULT;
        end
      end

      S_DECODE: begin
        // Capture the class once so later states do not depend on IR timing.
        op_d    = opcode_i;
        state_d = op_is_legal(opcode_i) ? S_EXEC : S_FAULT;
      end

      S_EXEC: begin
        alu_src_imm_o = (op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_ADDI);
        case (op_q)
          OP_BEQ: begin
            if (alu_zero_i) begin
              pc_d = branch_tgt_i;
            end
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          OP_R, OP_ADDI: state_d = S_WB;
          OP_HALT: begin
            retire  = 1'b1;
            state_d = S_HALT;
          end
          default: state_d = S_FAULT;
        endcase
      end

      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (op_q == OP_SW);
        timer_clr  = dmem_ack_i;
        timer_en   = !dmem_ack_i;
        if (dmem_ack_i) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timer_expired) begin
          state_d = S_FAULT;
        end
      end

      S_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = (op_q == OP_LW);
        retire       = 1'b1;
        state_d      = S_FETCH;
      end

      S_HALT: begin
        halted_o = 1'b1;
      end

      S_FAULT: begin
        fault_o = 1'b1;
      end

      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (retired_ld_i) begin
      retired_d = retired_ld_val_i;
    end else if (retire) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      op_q      <= OP_R;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  assign pc_o      = pc_q;
  assign retired_o = retired_q;
  assign state_o   = state_q;

endmodule
